// File: rtl/stk_cmd_arb.sv
// stk_cmd_arb: round-robin arbiter sharing one stack engine port, routing in-order responses back to requesters.
module stk_cmd_arb #(
  parameter int CMD_N         = 4,
  parameter int DAT_W         = 128,
  parameter int OUTSTANDING_N = 4,
  parameter int ID_W          = $clog2(CMD_N)
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [CMD_N-1:0][1:0]       i_cmd_opcode,
  input  logic [CMD_N-1:0][DAT_W-1:0] i_cmd_dat,
  output logic [CMD_N-1:0]            o_cmd_ack,
  output logic                        o_stk_vld,
  output logic [1:0]                  o_stk_opcode,
  output logic [DAT_W-1:0]            o_stk_dat,
  input  logic                        i_stk_rdy,
  input  logic                        i_stk_rsp_vld,
  input  logic [DAT_W-1:0]            i_stk_rsp_dat,
  output logic [CMD_N-1:0]            o_rsp_vld,
  output logic [DAT_W-1:0]            o_rsp_dat,
  output logic                        o_busy,
  output logic                        o_err
);
  localparam int PW = $clog2(OUTSTANDING_N);
  localparam int CW = PW + 1;

  logic [ID_W-1:0]  rr_q, rr_d, gnt, idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CMD_N-1:0] req, rsp_vld_q, rsp_vld_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic             err_q, err_d, xfer, pop;
  logic [OUTSTANDING_N-1:0][ID_W-1:0] fifo_q;

  always_comb begin
    for (int i = 0; i < CMD_N; i++) req[i] = i_cmd_opcode[i] == 2'd1 || i_cmd_opcode[i] == 2'd2;
  end

  // Scan downward so the nearest active requester at/after the pointer wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = CMD_N - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_q) + k) % CMD_N);
      if (req[idx]) gnt = idx;
    end
  end

  // Issue credit uses the registered count only; a same-cycle retire does not free a slot.
  assign o_stk_vld    = arst_n && cnt_q < CW'(OUTSTANDING_N) && |req;
  assign o_stk_opcode = i_cmd_opcode[gnt];
  assign o_stk_dat    = i_cmd_dat[gnt];
  assign xfer         = o_stk_vld & i_stk_rdy;
  assign o_cmd_ack    = xfer ? CMD_N'(1) << gnt : '0;
  assign pop          = i_stk_rsp_vld && cnt_q != '0;

  always_comb begin
    rr_d      = xfer ? (gnt == ID_W'(CMD_N - 1) ? '0 : gnt + 1'b1) : rr_q;
    cnt_d     = cnt_q + CW'(xfer) - CW'(pop);
    wr_d      = wr_q + PW'(xfer);
    rd_d      = rd_q + PW'(pop);
    rsp_vld_d = pop ? CMD_N'(1) << fifo_q[rd_q] : '0;
    rsp_dat_d = pop ? i_stk_rsp_dat : rsp_dat_q;
    err_d     = err_q | (i_stk_rsp_vld && cnt_q == '0);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_q      <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) fifo_q[wr_q] <= gnt;
  end

  assign o_rsp_vld = rsp_vld_q;
  assign o_rsp_dat = rsp_dat_q;
  assign o_busy    = cnt_q != '0;
  assign o_err     = err_q;
endmodule
